// File: rtl/gpio_pkg.sv
// Shared GPIO constants: bus width and debounce defaults.
package gpio_pkg;

    localparam int GPIO_W               = 16;
    localparam int DEFAULT_PRESCALE     = 1000;
    localparam int DEFAULT_STABLE_TICKS = 8;

    // Width of a counter that must hold values 0..max_val.
    function automatic int count_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One switch bit: two-flop synchronizer followed by a tick-driven stability
// filter that accepts a new level only after STABLE_TICKS consecutive
// differing samples.
module gpio_debounce_bit
    import gpio_pkg::*;
#(
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
    input  logic clock,
    input  logic reset,
    input  logic sample_tick,
    input  logic sw_raw,
    output logic level,
    output logic changed
);

    localparam int              CW       = count_width(STABLE_TICKS);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          s1_reg;
    logic          s2_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          level_reg;
    logic          level_next;
    logic          changed_reg;
    logic          changed_next;

    // Synchronizer pair; the raw pin is asynchronous to clock.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= sw_raw;
            s2_reg <= s1_reg;
        end
    end

    // Filter decision: any matching sample clears the run, a full run flips the level.
    always_comb begin
        cnt_next     = cnt_reg;
        level_next   = level_reg;
        changed_next = 1'b0;
        if (sample_tick) begin
            if (s2_reg == level_reg) begin
                cnt_next = '0;
            end else if (cnt_reg == CNT_LAST) begin
                cnt_next     = '0;
                level_next   = s2_reg;
                changed_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    // Filter state: run counter, accepted level and the one-cycle change pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            changed_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            level_reg   <= level_next;
            changed_reg <= changed_next;
        end
    end

    assign level   = level_reg;
    assign changed = changed_reg;

endmodule

// File: rtl/gpio_sw_debounce.sv
// Slide-switch conditioner for the APB GPIO slave: a shared sample-tick
// prescaler feeding GPIO_W independent per-bit debounce filters.
module gpio_sw_debounce
    import gpio_pkg::*;
#(
    parameter int PRESCALE     = DEFAULT_PRESCALE,
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [GPIO_W-1:0] sw_raw,
    output logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] sw_changed,
    output logic              sample_tick
);

    localparam int            PW        = count_width(PRESCALE - 1);
    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt_reg;
    logic [PW-1:0] pcnt_next;
    logic          tick_reg;

    // Prescaler wraps at PRESCALE-1; with PRESCALE = 1 it sits at 0 and ticks every cycle.
    always_comb begin
        pcnt_next = pcnt_reg + PW'(1);
        if (pcnt_reg == PCNT_LAST) begin
            pcnt_next = '0;
        end
    end

    // Prescaler count and registered tick (high the cycle after the terminal count).
    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt_reg <= '0;
            tick_reg <= 1'b0;
        end else begin
            pcnt_reg <= pcnt_next;
            tick_reg <= (pcnt_reg == PCNT_LAST);
        end
    end

    assign sample_tick = tick_reg;

    generate
        for (genvar gi = 0; gi < GPIO_W; gi++) begin : g_bit
            gpio_debounce_bit #(
                .STABLE_TICKS(STABLE_TICKS)
            ) u_bit (
                .clock      (clock),
                .reset      (reset),
                .sample_tick(tick_reg),
                .sw_raw     (sw_raw[gi]),
                .level      (gpio_in[gi]),
                .changed    (sw_changed[gi])
            );
        end
    endgenerate

endmodule

// File: doc/gpio_sw_debounce.md
# gpio_sw_debounce

Conditions the 16 raw slide-switch inputs from the board before they reach the APB GPIO slave's `gpio_in` port. Each bit passes through a two-flop synchronizer, then a per-bit stability filter clocked by a shared sample tick. The block presents a clean, glitch-free `gpio_in` vector plus one-cycle change pulses. It sits between the board pins and the GPIO slave's switch-register read path, in the same clock domain as the APB bus.

## Interface
- `PRESCALE`, default 1000: clock cycles per sample tick; legal range ≥ 1.
- `STABLE_TICKS`, default 8: consecutive differing samples required to accept a new level; legal range ≥ 1.
- `clock`  in  1  system clock, shared with the APB GPIO slave.
- `reset`  in  1  synchronous, active-high reset.
- `sw_raw`  in  16  asynchronous switch pins.
- `gpio_in`  out  16  debounced switch levels; drives the GPIO slave's `gpio_in`.
- `sw_changed`  out  16  per-bit one-cycle pulse, asserted on the cycle `gpio_in[i]` takes its new value.
- `sample_tick`  out  1  one-cycle pulse per sample period; for bench and visibility.

## Operation
- Synchronizer: `s1 <= sw_raw`, `s2 <= s1` every cycle. Only `s2` feeds the filter.
- Prescaler: `pcnt` counts 0..PRESCALE-1 and wraps to 0.
  - `sample_tick` = 1 when `pcnt == PRESCALE-1`. It is registered, so it is high in the cycle that follows that count.
  - With PRESCALE = 1, `sample_tick` is high every cycle after reset.
- Per-bit filter, with counter `cnt[i]` of width $clog2(STABLE_TICKS+1). The filter acts only on cycles where `sample_tick` is high:
  - If `s2[i] == gpio_in[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == STABLE_TICKS-1`: `gpio_in[i] <= s2[i]`, `cnt[i] <= 0`, `sw_changed[i] <= 1`.
  - Else: `cnt[i] <= cnt[i] + 1`.
- On non-tick cycles, `cnt` and `gpio_in` hold and `sw_changed` is 0.
- Glitch rejection: any sample that matches `gpio_in[i]` clears the count. A new level is accepted only after STABLE_TICKS consecutive differing samples.
- All 16 bits are independent. Simultaneous changes on several bits produce simultaneous pulses in the same cycle.
- No bus interface. This block has no registers visible to software.

## Timing
- Reset values: `s1`, `s2`, `pcnt`, `cnt`, `gpio_in`, `sw_changed` and `sample_tick` are all 0.
  - A switch held high through reset is reported as a 0→1 change after the normal filter latency.
- Reset asserted mid-count clears all state in the next cycle, with no partial pulse. The prescaler restarts from 0.
- Synchronizer latency is 2 cycles: a raw change set up before edge k appears on `s2` after edge k+1.
- With PRESCALE = 1, `gpio_in` updates at edge k+1+STABLE_TICKS, i.e. STABLE_TICKS+2 cycles after the raw change. `sw_changed` is high for exactly that one cycle.
- With general PRESCALE, latency is between 2+(STABLE_TICKS-1)·PRESCALE+1 and 2+STABLE_TICKS·PRESCALE cycles, depending on tick phase.
- `sw_changed` never stays high for more than one cycle per accepted transition.
- Counter saturation cannot occur: the count is bounded by STABLE_TICKS-1 before it resets.

## Structure
- Shared package `gpio_pkg`:
  - `GPIO_W = 16`
  - default `PRESCALE`
  - default `STABLE_TICKS`
  - The APB GPIO slave reuses `GPIO_W`.
- One sub-module, `gpio_debounce_bit`, is instantiated 16× via generate. It contains the synchronizer pair, `cnt`, the level flop and the pulse flop.
- Top level holds the shared prescaler and the `sample_tick` register.

## Test plan
Bench parameters are PRESCALE = 4 and STABLE_TICKS = 3 unless noted.

1. Reset check: hold reset for 3 cycles with `sw_raw = 16'hFFFF`. All outputs must read 0 during reset. After release, `gpio_in` becomes 16'hFFFF within 2+3·4 = 14 cycles, and `sw_changed` pulses 16'hFFFF for one cycle.
2. Clean edge, PRESCALE = 1: step `sw_raw[0]` from 0 to 1. `gpio_in[0]` rises exactly 5 cycles later, and `sw_changed[0]` is high for exactly that cycle.
3. Glitch rejection: pulse `sw_raw[5]` high for 6 cycles, spanning fewer than 3 ticks, then return it low. `gpio_in[5]` and `sw_changed[5]` must stay 0. Also toggle high/low each tick for 20 ticks; there must be no change.
4. Simultaneous changes: change `sw_raw` from 16'h0000 to 16'hA5C3 in one cycle. After the filter latency, `gpio_in = 16'hA5C3` and `sw_changed = 16'hA5C3` in a single cycle.
5. Reset mid-count: raise `sw_raw[3]` and assert reset after 2 ticks. `cnt` clears and no pulse is emitted. After release, the full latency applies again from 0.
6. Tick cadence: with `sw_raw` static, `sample_tick` must pulse exactly every 4 cycles. Then check PRESCALE = 1 and STABLE_TICKS = 1: any raw change appears on `gpio_in` 3 cycles later.
